// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its
// optional "101" self-check counter.
package seq_pkg;

    localparam int WORD_W_DEF = 8;
    localparam int REP_W_DEF  = 4;

    localparam logic [2:0] DET_PATTERN = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating counter of overlapping DET_PATTERN occurrences in a bit stream;
// the pattern only matches once two earlier valid bits are in the history.
module seq_match_cnt
    import seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       in_bit,
    input  logic       bit_valid,
    output logic [7:0] count
);

    logic [1:0] hist_q;
    logic [1:0] fill_q;
    logic [7:0] count_q;

    // History shift register, fill tracking and match counter.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            hist_q  <= 2'b00;
            fill_q  <= 2'b00;
            count_q <= 8'd0;
        end else if (bit_valid) begin
            if (fill_q == 2'b11 && {hist_q, in_bit} == DET_PATTERN) begin
                count_q <= sat_inc8(count_q);
            end
            hist_q <= {hist_q[0], in_bit};
            fill_q <= {fill_q[0], 1'b1};
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends the low len bits of a word MSB-first,
// rep+1 times back to back. Optional det_count under SEQ_GEN_SELFCHECK_EN.
module seq_gen
    import seq_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int REP_W  = REP_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WORD_W-1:0]     load_data,
    input  logic [$clog2(WORD_W):0] load_len,
    input  logic [REP_W-1:0]      load_rep,
    output logic                  x,
    output logic                  x_valid,
    output logic                  busy,
    output logic                  done
`ifdef SEQ_GEN_SELFCHECK_EN
    ,
    output logic [7:0]            det_count
`endif
);

    localparam int                LEN_W    = $clog2(WORD_W) + 1;
    localparam logic [LEN_W-1:0]  WORD_LEN = LEN_W'(WORD_W);
    localparam logic [LEN_W-1:0]  ONE_L    = LEN_W'(1);
    localparam logic [WORD_W-1:0] ONE_W    = WORD_W'(1);

    state_e             state_q;
    logic [WORD_W-1:0]  data_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [REP_W-1:0]   rep_q;
    logic               x_q;
    logic               x_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               load_ready_q;

    logic               accept;
    logic [LEN_W-1:0]   eff_len;
    logic [LEN_W-1:0]   idx_d;
    logic [WORD_W-1:0]  load_mask;
    logic [WORD_W-1:0]  data_mask;

    // Handshake, length clamping and next-bit selection.
    always_comb begin
        accept = load_valid && load_ready_q;
        if (load_len == '0 || load_len > WORD_LEN) begin
            eff_len = WORD_LEN;
        end else begin
            eff_len = load_len;
        end
        // Bit 0 wraps back to the top bit for the next repetition.
        if (idx_q != '0) begin
            idx_d = idx_q - ONE_L;
        end else begin
            idx_d = len_q - ONE_L;
        end
        load_mask = ONE_W << (eff_len - ONE_L);
        data_mask = ONE_W << idx_d;
    end

    // Main FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            rep_q        <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q      <= SEND;
                        data_q       <= load_data;
                        len_q        <= eff_len;
                        idx_q        <= eff_len - ONE_L;
                        rep_q        <= load_rep;
                        x_q          <= |(load_data & load_mask);
                        x_valid_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                    end else begin
                        x_q          <= 1'b0;
                        x_valid_q    <= 1'b0;
                        busy_q       <= 1'b0;
                        load_ready_q <= 1'b1;
                    end
                    done_q <= 1'b0;
                end
                SEND: begin
                    if (idx_q == '0 && rep_q == '0) begin
                        state_q   <= DONE;
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        if (idx_q == '0) begin
                            rep_q <= rep_q - REP_W'(1);
                        end
                        idx_q <= idx_d;
                        x_q   <= |(data_q & data_mask);
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
                default: begin
                    state_q      <= IDLE;
                    x_q          <= 1'b0;
                    x_valid_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready = load_ready_q;
    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef SEQ_GEN_SELFCHECK_EN
    seq_match_cnt u_match_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (accept),
        .in_bit    (x_q),
        .bit_valid (x_valid_q),
        .count     (det_count)
    );
`endif

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: stream shape, repeat, length clamping,
// reset abort and load handshake while busy.
module tb_seq_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic [3:0] load_len;
    logic [3:0] load_rep;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       done;
`ifdef SEQ_GEN_SELFCHECK_EN
    logic [7:0] det_count;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    seq_gen #(.WORD_W(8), .REP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
`ifdef SEQ_GEN_SELFCHECK_EN
        ,
        .det_count  (det_count)
`endif
    );

    // Called at the negedge of cycle T; returns at the negedge of T+1.
    task automatic start_load(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
        load_valid = 1'b1;
        load_data  = d;
        load_len   = l;
        load_rep   = r;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_state: x=%b x_valid=%b busy=%b done=%b load_ready=%b, expected 0 0 0 0 1",
                     x, x_valid, busy, done, load_ready);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_a5();
        logic [15:0] e;
        e = 16'h00A5;
        vec_cnt++;
        if (load_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL a5_ready: load_ready=%b, expected 1", load_ready);
        end
        start_load(8'hA5, 4'd8, 4'd0);
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== e[7-i] || busy !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL a5_bit%0d: x=%b x_valid=%b busy=%b done=%b, expected x=%b x_valid=1 busy=1 done=0",
                         i, x, x_valid, busy, done, e[7-i]);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (done !== 1'b1 || x_valid !== 1'b0 || x !== 1'b0 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL a5_done: done=%b x_valid=%b x=%b busy=%b, expected 1 0 0 1", done, x_valid, x, busy);
        end
`ifdef SEQ_GEN_SELFCHECK_EN
        vec_cnt++;
        if (det_count !== 8'd2) begin
            err_cnt++;
            $display("FAIL a5_det_count: got %0d, expected 2", det_count);
        end
`endif
        @(negedge clk);
        vec_cnt++;
        if (load_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL a5_idle: load_ready=%b busy=%b done=%b, expected 1 0 0", load_ready, busy, done);
        end
    endtask

    task automatic test_repeat();
        logic [15:0] e;
        e = 16'b0000000101101101;
        start_load(8'b00000101, 4'd3, 4'd2);
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== e[8-i] || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL rep_bit%0d: x=%b x_valid=%b done=%b, expected x=%b x_valid=1 done=0",
                         i, x, x_valid, done, e[8-i]);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (done !== 1'b1 || x_valid !== 1'b0 || x !== 1'b0) begin
            err_cnt++;
            $display("FAIL rep_done: done=%b x_valid=%b x=%b, expected 1 0 0", done, x_valid, x);
        end
`ifdef SEQ_GEN_SELFCHECK_EN
        vec_cnt++;
        if (det_count !== 8'd3) begin
            err_cnt++;
            $display("FAIL rep_det_count: got %0d, expected 3", det_count);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_len_clamp();
        logic [15:0] e;
        // len=0 means the full 8-bit word, sent twice.
        start_load(8'hFF, 4'd0, 4'd1);
        for (int i = 0; i < 16; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== 1'b1 || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL len0_bit%0d: x=%b x_valid=%b done=%b, expected 1 1 0", i, x, x_valid, done);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (done !== 1'b1 || x_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL len0_done: done=%b x_valid=%b, expected 1 0", done, x_valid);
        end
        @(negedge clk);
        e = 16'h003C;
        start_load(8'h3C, 4'd12, 4'd0);
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== e[7-i] || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL len12_bit%0d: x=%b x_valid=%b done=%b, expected x=%b x_valid=1 done=0",
                         i, x, x_valid, done, e[7-i]);
            end
            @(negedge clk);
        end
        vec_cnt++;
        if (done !== 1'b1 || x_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL len12_done: done=%b x_valid=%b, expected 1 0", done, x_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_len1();
        start_load(8'h01, 4'd1, 4'd0);
        vec_cnt++;
        if (x_valid !== 1'b1 || x !== 1'b1 || busy !== 1'b1 || load_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL len1_bit: x=%b x_valid=%b busy=%b load_ready=%b, expected 1 1 1 0",
                     x, x_valid, busy, load_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b1 || x_valid !== 1'b0 || load_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL len1_done: done=%b x_valid=%b load_ready=%b, expected 1 0 0", done, x_valid, load_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (load_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL len1_ready: load_ready=%b done=%b busy=%b, expected 1 0 0", load_ready, done, busy);
        end
    endtask

    task automatic test_reset_mid();
        start_load(8'hA5, 4'd8, 4'd0);
        @(negedge clk);
        @(negedge clk);
        vec_cnt++;
        if (x_valid !== 1'b1 || x !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_bit3: x=%b x_valid=%b, expected 1 1", x, x_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vec_cnt++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_state: x_valid=%b busy=%b load_ready=%b done=%b, expected 0 0 1 0",
                     x_valid, busy, load_ready, done);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (done !== 1'b0 || x_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL abort_quiet%0d: done=%b x_valid=%b, expected 0 0", i, done, x_valid);
            end
        end
        // Reset wins over a load presented in the same cycle.
        reset      = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hFF;
        load_len   = 4'd8;
        load_rep   = 4'd0;
        @(negedge clk);
        reset      = 1'b0;
        load_valid = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || x_valid !== 1'b0 || load_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_prio: busy=%b x_valid=%b load_ready=%b, expected 0 0 1", busy, x_valid, load_ready);
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || x_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_prio_after: busy=%b x_valid=%b, expected 0 0", busy, x_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        bit          seen;
        e = 16'h00C3;
        load_valid = 1'b1;
        load_data  = 8'hC3;
        load_len   = 4'd8;
        load_rep   = 4'd0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== e[7-i] || load_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL b2b_bit%0d: x=%b x_valid=%b load_ready=%b, expected x=%b x_valid=1 load_ready=0",
                         i, x, x_valid, load_ready, e[7-i]);
            end
            load_data = 8'($urandom_range(255, 0));
            load_len  = 4'($urandom_range(15, 0));
            load_rep  = 4'($urandom_range(15, 0));
            @(negedge clk);
        end
        vec_cnt++;
        if (done !== 1'b1 || load_ready !== 1'b0 || x_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_done: done=%b load_ready=%b x_valid=%b, expected 1 0 0", done, load_ready, x_valid);
        end
        load_data = 8'h81;
        load_len  = 4'd8;
        load_rep  = 4'd0;
        @(negedge clk);
        vec_cnt++;
        if (load_ready !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_ready: load_ready=%b x_valid=%b busy=%b, expected 1 0 0", load_ready, x_valid, busy);
        end
        @(negedge clk);
        load_valid = 1'b0;
        e = 16'h0081;
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (x_valid !== 1'b1 || x !== e[7-i] || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_second_bit%0d: x=%b x_valid=%b busy=%b, expected x=%b x_valid=1 busy=1",
                         i, x, x_valid, busy, e[7-i]);
            end
            @(negedge clk);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        vec_cnt++;
        if (seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_second_done: done not seen within 4 cycles, expected done pulse");
        end
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_len   = 4'd0;
        load_rep   = 4'd0;
        test_reset();
        test_a5();
        test_repeat();
        test_len_clamp();
        test_len1();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
